// File: rtl/dmem_bridge.sv
// dmem_bridge: turns single-cycle MEM-stage accesses into valid/ready bus beats, extends
// load data, stalls the pipeline while busy and flags illegal accesses and bus timeouts.
module dmem_bridge #(
  parameter int TIMEOUT = 255,
  parameter int TMO_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rsp_rdata,
  output logic        mem_stall,
  output logic        fault,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic we_q;
  logic [2:0] f3_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0] be_q;
  logic [TMO_W-1:0] cnt;
  logic legal, start, tmo, fin;
  logic [3:0] be;
  logic [31:0] lanes, shifted, ext;
  always_comb begin
    legal = req_we ? req_funct3 <= 3'd2 : (req_funct3[1:0] != 2'd3 && req_funct3 != 3'd6);
    legal = legal && !(req_funct3[1:0] == 2'd1 && req_addr[0])
                  && !(req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
    be = req_funct3[1:0] == 2'd0 ? 4'b0001 << req_addr[1:0] :
         req_funct3[1:0] == 2'd1 ? 4'b0011 << req_addr[1:0] : 4'b1111;
    lanes = req_funct3[1:0] == 2'd0 ? {4{req_wdata[7:0]}} :
            req_funct3[1:0] == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
    shifted = bus_rdata >> {addr_q[1:0], 3'b000};
    ext = f3_q == 3'd0 ? {{24{shifted[7]}}, shifted[7:0]} :
          f3_q == 3'd1 ? {{16{shifted[15]}}, shifted[15:0]} :
          f3_q == 3'd4 ? {24'd0, shifted[7:0]} :
          f3_q == 3'd5 ? {16'd0, shifted[15:0]} : bus_rdata;
  end
  assign start = state == IDLE && req_valid && legal;
  // ready in the terminal-count cycle wins over the timeout
  assign tmo = state == REQ && !bus_ready && cnt == TMO_W'(TIMEOUT - 1);
  assign fin = state == REQ && (bus_ready || tmo);
  assign mem_stall = start || state == REQ;
  assign fault = (state == IDLE && req_valid && !legal) || tmo;
  assign bus_valid = state == REQ;
  assign bus_we = bus_valid && we_q;
  assign bus_be = bus_valid ? be_q : 4'd0;
  assign bus_addr = bus_valid ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus_wdata = bus_valid ? wdata_q : 32'd0;
  assign rsp_rdata = state == DONE ? rdata_q : 32'd0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      we_q <= 1'b0;
      f3_q <= 3'd0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q <= '0;
      cnt <= '0;
    end else begin
      state <= start ? REQ : state == REQ ? (fin ? DONE : REQ) : IDLE;
      cnt <= (state == REQ && !bus_ready) ? cnt + 1'b1 : '0;
      if (start) begin
        we_q <= req_we;
        f3_q <= req_funct3;
        addr_q <= req_addr;
        wdata_q <= lanes;
        be_q <= be;
      end
      if (fin) rdata_q <= (bus_ready && !we_q) ? ext : 32'd0;
    end
  end
endmodule
